// File: rtl/sha256_msg_loader_if.sv
// Block handshake between the message loader and the SHA-256 hash core.
// master drives a buffered 512-bit block; slave answers with blk_ready.
interface sha256_msg_loader_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic [7:0]   blk_idx;

  modport master (output blk_valid, blk_data, blk_last, blk_idx, input blk_ready);
  modport slave  (input blk_valid, blk_data, blk_last, blk_idx, output blk_ready);
endinterface

// File: rtl/sha256_msg_loader.sv
// Fetches NUM_OF_WORDS words, appends SHA-256 padding, presents 512-bit blocks (one buffered; 2 cyc/mem word, 1 cyc/pad word).
// Fill stalls in PRESENT until blk_ready. SHA256_LOADER_BSWAP_EN byte-reverses memory words.
module sha256_msg_loader #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [15:0]                message_addr,
  output logic                       mem_clk,
  output logic                       mem_we,
  output logic [15:0]                mem_addr,
  input  logic [31:0]                mem_read_data,
  output logic                       done,
  sha256_msg_loader_if.master        blk
);

  localparam int          NB       = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam logic [10:0] N_W      = 11'(NUM_OF_WORDS);
  localparam logic [10:0] LAST_W   = 11'(16 * NB - 1);
  localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);
  localparam logic [7:0]  LAST_IDX = 8'(NB - 1);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, PAD, PRESENT} state_e;

  state_e             state_q, state_d;
  logic [10:0]        wc_q, wc_d;
  logic [15:0]        base_q, base_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic               blk_valid_q, blk_valid_d;
  logic [7:0]         blk_idx_q, blk_idx_d;
  logic [15:0][31:0]  buf_q;
  logic               wr_en;
  logic [31:0]        wr_dat;
  logic [31:0]        mem_word;
  logic [31:0]        pad_word;
  logic [10:0]        wc_inc;
  logic               is_last;

  assign wc_inc  = wc_q + 11'd1;
  assign is_last = (blk_idx_q == LAST_IDX);

`ifdef SHA256_LOADER_BSWAP_EN
  assign mem_word = {mem_read_data[7:0], mem_read_data[15:8],
                     mem_read_data[23:16], mem_read_data[31:24]};
`else
  assign mem_word = mem_read_data;
`endif

  // Upper length word (16*NB-2) falls into the zero case.
  assign pad_word = (wc_q == N_W)    ? 32'h8000_0000 :
                    (wc_q == LAST_W) ? LEN_BITS      : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RADDR;
      RADDR:   state_d = RDATA;
      RDATA: begin
        if (wc_q[3:0] == 4'd15) state_d = PRESENT;
        else if (wc_inc < N_W)  state_d = RADDR;
        else                    state_d = PAD;
      end
      PAD:     if (wc_q[3:0] == 4'd15) state_d = PRESENT;
      PRESENT: begin
        if (blk.blk_ready) begin
          if (is_last)          state_d = IDLE;
          else if (wc_q < N_W)  state_d = RADDR;
          else                  state_d = PAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wc_d      = wc_q;
    base_d    = base_q;
    blk_idx_d = blk_idx_q;
    wr_en     = 1'b0;
    wr_dat    = 32'h0;
    case (state_q)
      IDLE: if (start) begin
        base_d    = message_addr;
        wc_d      = 11'd0;
        blk_idx_d = 8'd0;
      end
      RDATA: begin
        wr_en  = 1'b1;
        wr_dat = mem_word;
        wc_d   = wc_inc;
      end
      PAD: begin
        wr_en  = 1'b1;
        wr_dat = pad_word;
        wc_d   = wc_inc;
      end
      PRESENT: if (blk.blk_ready) blk_idx_d = blk_idx_q + 8'd1;
      default: ;
    endcase
    blk_valid_d = (state_d == PRESENT);
    // Address is registered so it is already on the bus throughout RADDR.
    mem_addr_d  = (state_d == RADDR) ? base_d + {5'd0, wc_d} : mem_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wc_q        <= '0;
      base_q      <= '0;
      mem_addr_q  <= '0;
      blk_valid_q <= 1'b0;
      blk_idx_q   <= '0;
      buf_q       <= '0;
    end else begin
      wc_q        <= wc_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      blk_valid_q <= blk_valid_d;
      blk_idx_q   <= blk_idx_d;
      if (wr_en) buf_q[4'd15 - wc_q[3:0]] <= wr_dat;
    end
  end

  assign mem_clk       = clk;
  assign mem_we        = 1'b0;
  assign mem_addr      = mem_addr_q;
  assign done          = (state_q == IDLE);
  assign blk.blk_valid = blk_valid_q;
  assign blk.blk_data  = buf_q;
  assign blk.blk_idx   = blk_idx_q;
  assign blk.blk_last  = blk_valid_q && is_last;

endmodule
